uart_rx_frame: RTL
==================

# uart_rx_frame

Parametrised UART receiver for the DV verification-IP library (bench-side monitor and loop-back checker). It supports 5–9 data bits, optional odd/even parity and 1 or 2 stop bits. It reports parity, framing, break and overrun conditions, and delivers each received word through a valid/ready holding register rather than a single-cycle strobe. It sits between a DUT serial TX pin and the bench scoreboard.

## Interface
- CLKS_PER_BIT, 87, i_Clock cycles per bit; legal range ≥ 4.
- DATA_BITS, 8, data bits per frame; legal range 5..9.
- PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.

- i_Clock  input  1  sole clock; all state changes on its rising edge.
- i_Reset  input  1  asynchronous, active-high reset.
- i_Rx_Serial  input  1  serial line; idle level is high.
- o_Rx_Valid  output  1  o_Rx_Data and error flags are held and valid.
- i_Rx_Ready  input  1  consumer accepts the word when o_Rx_Valid && i_Rx_Ready.
- o_Rx_Data  output  DATA_BITS  received word, LSB first on the line.
- o_Parity_Err  output  1  parity mismatch for the held word; forced 0 when PARITY = 0.
- o_Frame_Err  output  1  any stop-bit sample was 0 for the held word.
- o_Break  output  1  held word is a break.
- o_Overrun  output  1  one-cycle pulse: a frame completed while the holding register was still full.
- o_Busy  output  1  receiver FSM is not in IDLE.

## Operation
- **Input synchroniser:** i_Rx_Serial passes through a 2-flop synchroniser; both flops reset to 1. All decisions use the synchronised bit `rx`.
- **Half-bit point:** H = (CLKS_PER_BIT-1)/2, using integer division.
- **Counters:** 32-bit cycle counter and 4-bit bit index.
- **FSM states:**
  - IDLE: counter = 0, index = 0. If rx = 0, go to START.
  - START: count to H, then sample rx. If rx = 1, this is a false start: go to IDLE with no output. If rx = 0, clear the counter and go to DATA.
  - DATA: when the counter reaches CLKS_PER_BIT-1, sample rx into shift[index] and clear the counter. After DATA_BITS samples, go to PARITY (if PARITY ≠ 0) or STOP.
  - PARITY: sample one bit at CLKS_PER_BIT-1. Error if (XOR of data bits ^ parity bit) ≠ (PARITY = 1 ? 1 : 0).
  - STOP: sample STOP_BITS bits, each at CLKS_PER_BIT-1. Any 0 sample sets the frame error. After the last sample, go to DELIVER.
  - DELIVER (1 cycle): load the holding register, or flag overrun (see below). Then go to IDLE if rx = 1, else go to BRKWAIT.
  - BRKWAIT: remain until rx = 1, then go to IDLE. This prevents a held-low line from being decoded as repeated frames.
- **Break:** all data bits, the parity bit (if present) and all stop samples are 0. A break also sets o_Frame_Err. o_Rx_Data = 0.
- **Holding register load:** if o_Rx_Valid = 0, or i_Rx_Ready = 1 in the same cycle, load data and flags and set o_Rx_Valid = 1.
- **Overrun:** otherwise keep the old word, drop the new one, and pulse o_Overrun.
- **Accept:** o_Rx_Valid clears on the cycle after o_Rx_Valid && i_Rx_Ready, unless a DELIVER load occurs in that same cycle.
- **Error flag lifetime:** error flags are only meaningful while o_Rx_Valid = 1. They change only on a load.

## Timing
- **Reset values:** o_Rx_Valid = 0, o_Rx_Data = 0, all flags = 0, o_Overrun = 0, o_Busy = 0, FSM = IDLE, synchroniser = 1.
- **Reset mid-frame:** aborts immediately. After release, a low line is treated as a new start edge.
- **Latency:** let t be the first cycle IDLE sees rx = 0.
  - The start sample is at t+1+H.
  - Each subsequent sample is CLKS_PER_BIT cycles after the previous one.
  - With N = DATA_BITS + (PARITY≠0) + STOP_BITS, the last sample is at t+1+H+N·CLKS_PER_BIT.
  - o_Rx_Valid is high from the cycle after DELIVER, i.e. t+3+H+N·CLKS_PER_BIT.
  - Add 2 cycles of synchroniser delay when measuring from the pin.
- **Back-to-back frames:** after DELIVER the receiver returns to IDLE about half a bit before the nominal stop-bit end. Frames with a zero-length idle gap are therefore received without loss.
- **o_Busy:** high in every state except IDLE.

## Test plan
- CLKS_PER_BIT=8, DATA_BITS=8, PARITY=2, STOP_BITS=1; send 0xA5 with parity 0 and i_Rx_Ready=1 → o_Rx_Valid for 1 cycle, o_Rx_Data=0xA5, all flags 0, valid edge at the computed latency ±0.
- Same configuration, 0xA5 with parity bit 1 → o_Parity_Err=1, data 0xA5. Then 0x3C with stop bit 0 → o_Frame_Err=1, o_Break=0.
- Line held low for 3 frame times → exactly one word with o_Break=1, o_Frame_Err=1, data 0x00. No further words until the line returns high; the next normal frame 0x55 is received correctly.
- i_Rx_Ready=0; send 0x11 then 0x22 back-to-back → o_Rx_Data stays 0x11 and o_Overrun pulses once at the second DELIVER. Raise ready → accept 0x11, valid drops.
- Low glitch of 2 cycles (< H) on an idle line → return to IDLE, no o_Rx_Valid. Then DATA_BITS=5, PARITY=1, STOP_BITS=2; send 0x13 → data 0x13, no errors.
- Assert i_Reset mid-DATA with a word held → all outputs 0 that cycle. After release, a fresh 0x7E frame is received cleanly.

Source files
------------

// File: rtl/uart_rx_frame_if.sv
// Received-word handshake between the UART receiver and its consumer.
// master: receiver side (drives word, flags, overrun); slave: consumer side.
interface uart_rx_frame_if #(
    parameter int DATA_BITS = 8
);
    logic                 o_Rx_Valid;
    logic                 i_Rx_Ready;
    logic [DATA_BITS-1:0] o_Rx_Data;
    logic                 o_Parity_Err;
    logic                 o_Frame_Err;
    logic                 o_Break;
    logic                 o_Overrun;

    modport master (
        output o_Rx_Valid, o_Rx_Data, o_Parity_Err, o_Frame_Err, o_Break, o_Overrun,
        input  i_Rx_Ready
    );

    modport slave (
        input  o_Rx_Valid, o_Rx_Data, o_Parity_Err, o_Frame_Err, o_Break, o_Overrun,
        output i_Rx_Ready
    );
endinterface

// File: rtl/uart_rx_frame.sv
// UART receiver: 5..9 data bits, optional odd/even parity, 1 or 2 stop bits.
// Each received word lands in a valid/ready holding register together with
// its parity/framing/break flags; a word arriving while the register is full
// is dropped and reported with a one-cycle overrun pulse.
module uart_rx_frame #(
    parameter int CLKS_PER_BIT = 87,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic            i_Clock,
    input  logic            i_Reset,
    input  logic            i_Rx_Serial,
    output logic            o_Busy,
    uart_rx_frame_if.master rx_if
);
    localparam logic [31:0] LAST    = 32'(CLKS_PER_BIT - 1);
    localparam logic [31:0] HALF    = 32'((CLKS_PER_BIT - 1) / 2);
    localparam logic [3:0]  D_LAST  = 4'(DATA_BITS - 1);
    localparam logic [3:0]  S_LAST  = 4'(STOP_BITS - 1);
    localparam logic        HAS_PAR = (PARITY != 0);
    localparam logic        PAR_ODD = (PARITY == 1);

    typedef enum logic [2:0] {
        IDLE, START, DATA, PAR, STOP, DELIVER, BRKWAIT
    } state_t;

    state_t               state_q, state_d;
    logic                 sync1_q, sync1_d;
    logic                 rx_q, rx_d;
    logic [31:0]          cnt_q, cnt_d;
    logic [3:0]           idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 pbit_q, pbit_d;     // sampled parity bit (0 when no parity)
    logic                 ferr_q, ferr_d;     // some stop sample was 0
    logic                 stop1_q, stop1_d;   // some stop sample was 1
    logic                 valid_q, valid_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 perr_q, perr_d;
    logic                 ferrh_q, ferrh_d;
    logic                 brk_q, brk_d;
    logic                 ovr_q, ovr_d;
    logic                 busy_q, busy_d;

    logic                 par_err_w;
    logic                 brk_w;
    logic                 load_w;

    // Frame-level verdicts, evaluated in DELIVER once every sample is in.
    always_comb begin
        par_err_w = HAS_PAR && ((^shift_q ^ pbit_q) != PAR_ODD);
        brk_w     = (shift_q == '0) && !pbit_q && !stop1_q;
        load_w    = (state_q == DELIVER) && (!valid_q || rx_if.i_Rx_Ready);
    end

    // Next-state logic for the receive FSM and the holding register.
    always_comb begin
        state_d = state_q;
        sync1_d = i_Rx_Serial;
        rx_d    = sync1_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        pbit_d  = pbit_q;
        ferr_d  = ferr_q;
        stop1_d = stop1_q;
        valid_d = valid_q;
        data_d  = data_q;
        perr_d  = perr_q;
        ferrh_d = ferrh_q;
        brk_d   = brk_q;
        ovr_d   = 1'b0;

        // Consumer accept; a same-cycle load below takes priority.
        if (valid_q && rx_if.i_Rx_Ready) valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d   = '0;
                idx_d   = '0;
                pbit_d  = 1'b0;
                ferr_d  = 1'b0;
                stop1_d = 1'b0;
                if (!rx_q) state_d = START;
            end
            START: begin
                if (cnt_q == HALF) begin
                    cnt_d   = '0;
                    // A start bit that is gone by mid-bit is a glitch.
                    state_d = rx_q ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            DATA: begin
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    // LSB arrives first, so shift in from the top.
                    shift_d = {rx_q, shift_q[DATA_BITS-1:1]};
                    idx_d   = idx_q + 4'd1;
                    if (idx_q == D_LAST) begin
                        idx_d   = '0;
                        state_d = HAS_PAR ? PAR : STOP;
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            PAR: begin
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    pbit_d  = rx_q;
                    state_d = STOP;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            STOP: begin
                if (cnt_q == LAST) begin
                    cnt_d = '0;
                    if (rx_q) stop1_d = 1'b1;
                    else      ferr_d  = 1'b1;
                    idx_d = idx_q + 4'd1;
                    if (idx_q == S_LAST) begin
                        idx_d   = '0;
                        state_d = DELIVER;
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            DELIVER: begin
                if (load_w) begin
                    valid_d = 1'b1;
                    data_d  = shift_q;
                    perr_d  = par_err_w;
                    ferrh_d = ferr_q;
                    brk_d   = brk_w;
                end else begin
                    ovr_d = 1'b1;
                end
                // A line still low here is a break; wait for it to release.
                state_d = rx_q ? IDLE : BRKWAIT;
            end
            BRKWAIT: begin
                if (rx_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // All state and registered outputs; reset aborts any frame in flight.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state_q <= IDLE;
            sync1_q <= 1'b1;
            rx_q    <= 1'b1;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            pbit_q  <= 1'b0;
            ferr_q  <= 1'b0;
            stop1_q <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            perr_q  <= 1'b0;
            ferrh_q <= 1'b0;
            brk_q   <= 1'b0;
            ovr_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sync1_q <= sync1_d;
            rx_q    <= rx_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            pbit_q  <= pbit_d;
            ferr_q  <= ferr_d;
            stop1_q <= stop1_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            perr_q  <= perr_d;
            ferrh_q <= ferrh_d;
            brk_q   <= brk_d;
            ovr_q   <= ovr_d;
            busy_q  <= busy_d;
        end
    end

    assign rx_if.o_Rx_Valid   = valid_q;
    assign rx_if.o_Rx_Data    = data_q;
    assign rx_if.o_Parity_Err = perr_q;
    assign rx_if.o_Frame_Err  = ferrh_q;
    assign rx_if.o_Break      = brk_q;
    assign rx_if.o_Overrun    = ovr_q;
    assign o_Busy             = busy_q;
endmodule
